// File: rtl/saturn_bus_pkg.sv
// Shared types and widths for the SH-2 C-bus arbiter.
//   owner_t     : who currently drives the C-bus address/data mux
//   arb_state_t : arbiter FSM states
//   TURN_CNT_W  : width of the turnaround counter
//   TO_CNT_W    : width of the master-release timeout counter
package saturn_bus_pkg;

    localparam int unsigned TURN_CNT_W = 3;
    localparam int unsigned TO_CNT_W   = 8;

    typedef enum logic [1:0] {
        OWN_MSH  = 2'd0,
        OWN_SSH  = 2'd1,
        OWN_SCU  = 2'd2,
        OWN_NONE = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        M_OWN,
        REQ_REL,
        TURN,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// C-bus arbiter: shares the SH-2 C-bus among the master SH-2 (default owner), the slave SH-2
// and the SCU DMA. The master is asked to release via MSH_BRLS_N/MSH_BGR_N; the other two
// requesters get BREQ_N/BACK_N handshakes. OWNER steers the top-level C-bus mux.
// Ports:
//   CLK, RST (async, active high), CE_R (clock enable for all state)
//   MSH_BRLS_N  out  release request to master SH-2 (low = please release)
//   MSH_BGR_N   in   master SH-2 has released the bus (low)
//   SSH_BREQ_N  in / SSH_BACK_N out  slave SH-2 request / grant (active low)
//   SCU_BREQ_N  in / SCU_BACK_N out  SCU DMA request / grant (active low)
//   OWNER       out  0 = MSH, 1 = SSH, 2 = SCU, 3 = none (turnaround)
//   REL_TO      out  sticky flag: master did not release within REL_TIMEOUT cycles
module cbus_arbiter
    import saturn_bus_pkg::*;
#(
    parameter int unsigned TURN_CYC    = 1,
    parameter int unsigned REL_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    output logic       MSH_BRLS_N,
    input  logic       MSH_BGR_N,
    input  logic       SSH_BREQ_N,
    output logic       SSH_BACK_N,
    input  logic       SCU_BREQ_N,
    output logic       SCU_BACK_N,
    output logic [1:0] OWNER,
    output logic       REL_TO
);

    // Turnaround ends on the TURN_CYC-th cycle spent in TURN.
    localparam logic [TURN_CNT_W-1:0] TurnLast = TURN_CNT_W'(TURN_CYC - 1);
    localparam logic [TO_CNT_W-1:0]   ToMax    = TO_CNT_W'(REL_TIMEOUT);
    localparam logic [TO_CNT_W-1:0]   ToLast   = TO_CNT_W'(REL_TIMEOUT - 1);

    arb_state_t              state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  last_q, last_d;
    owner_t                  winner;
    logic                    brls_n_q, brls_n_d;
    logic                    ssh_back_n_q, ssh_back_n_d;
    logic                    scu_back_n_q, scu_back_n_d;
    logic                    rel_to_q, rel_to_d;
    logic [TURN_CNT_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic [TO_CNT_W-1:0]     to_cnt_q, to_cnt_d;

    logic ssh_req, scu_req, owner_req;

    assign ssh_req   = ~SSH_BREQ_N;
    assign scu_req   = ~SCU_BREQ_N;
    assign owner_req = (owner_q == OWN_SSH) ? ssh_req : scu_req;

    // Pick the next requester; on contention alternate away from the last winner.
    always_comb begin
        winner = OWN_NONE;
        if (ssh_req && scu_req) begin
            winner = (last_q == OWN_SSH) ? OWN_SCU : OWN_SSH;
        end else if (ssh_req) begin
            winner = OWN_SSH;
        end else if (scu_req) begin
            winner = OWN_SCU;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        brls_n_d     = brls_n_q;
        ssh_back_n_d = ssh_back_n_q;
        scu_back_n_d = scu_back_n_q;
        rel_to_d     = rel_to_q;
        turn_cnt_d   = turn_cnt_q;
        to_cnt_d     = to_cnt_q;

        unique case (state_q)
            M_OWN: begin
                if (ssh_req || scu_req) begin
                    brls_n_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = REQ_REL;
                end
            end
            REQ_REL: begin
                if (!MSH_BGR_N) begin
                    owner_d    = OWN_NONE;
                    turn_cnt_d = '0;
                    state_d    = TURN;
                end else if (!ssh_req && !scu_req) begin
                    brls_n_d = 1'b1;
                    state_d  = M_OWN;
                end else begin
                    // Flag a stuck master but keep waiting; never force a grant.
                    if (to_cnt_q != ToMax) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                    if (to_cnt_q == ToLast) begin
                        rel_to_d = 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q != TurnLast) begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end else if (winner == OWN_NONE) begin
                    brls_n_d = 1'b1;
                    owner_d  = OWN_MSH;
                    state_d  = M_OWN;
                end else begin
                    ssh_back_n_d = (winner != OWN_SSH);
                    scu_back_n_d = (winner != OWN_SCU);
                    owner_d      = winner;
                    last_d       = winner;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                // MSH_BGR_N and the other requester are ignored while a tenure runs.
                if (!owner_req) begin
                    ssh_back_n_d = 1'b1;
                    scu_back_n_d = 1'b1;
                    owner_d      = OWN_NONE;
                    turn_cnt_d   = '0;
                    state_d      = TURN;
                end
            end
            default: state_d = M_OWN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= M_OWN;
            owner_q      <= OWN_MSH;
            last_q       <= OWN_SSH;
            brls_n_q     <= 1'b1;
            ssh_back_n_q <= 1'b1;
            scu_back_n_q <= 1'b1;
            rel_to_q     <= 1'b0;
            turn_cnt_q   <= '0;
            to_cnt_q     <= '0;
        end else if (CE_R) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            brls_n_q     <= brls_n_d;
            ssh_back_n_q <= ssh_back_n_d;
            scu_back_n_q <= scu_back_n_d;
            rel_to_q     <= rel_to_d;
            turn_cnt_q   <= turn_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign MSH_BRLS_N = brls_n_q;
    assign SSH_BACK_N = ssh_back_n_q;
    assign SCU_BACK_N = scu_back_n_q;
    assign OWNER      = owner_q;
    assign REL_TO     = rel_to_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus a randomised run compared
// against a transaction-level model of who owns the bus.
// Observed vector layout: {MSH_BRLS_N, SSH_BACK_N, SCU_BACK_N, OWNER[1:0], REL_TO}.
module tb_cbus_arbiter;

    localparam int unsigned TC = 1;
    localparam int unsigned RT = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_r = 1'b1;
    logic       msh_brls_n, msh_bgr_n, ssh_breq_n, ssh_back_n, scu_breq_n, scu_back_n, rel_to;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner 0 MSH, 1 SSH, 2 SCU, 3 none.
    bit m_ask;
    int m_owner, m_last, m_wait, m_idle;
    bit m_to;

    always #5 clk = ~clk;

    cbus_arbiter #(
        .TURN_CYC   (TC),
        .REL_TIMEOUT(RT)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .CE_R      (ce_r),
        .MSH_BRLS_N(msh_brls_n),
        .MSH_BGR_N (msh_bgr_n),
        .SSH_BREQ_N(ssh_breq_n),
        .SSH_BACK_N(ssh_back_n),
        .SCU_BREQ_N(scu_breq_n),
        .SCU_BACK_N(scu_back_n),
        .OWNER     (owner),
        .REL_TO    (rel_to)
    );

    function automatic logic [5:0] obs();
        return {msh_brls_n, ssh_back_n, scu_back_n, owner, rel_to};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_ask = 0; m_owner = 0; m_last = 1; m_wait = 0; m_idle = 0; m_to = 0;
    endtask

    // One enabled cycle of the bus-ownership rules, using the inputs about to be sampled.
    task automatic model_step();
        bit sr, cr;
        sr = !ssh_breq_n;
        cr = !scu_breq_n;
        if (m_owner == 0) begin
            if (!m_ask) begin
                if (sr || cr) begin m_ask = 1; m_wait = 0; end
            end else if (!msh_bgr_n) begin
                m_owner = 3; m_idle = TC;
            end else if (!sr && !cr) begin
                m_ask = 0;
            end else begin
                if (m_wait < RT) m_wait++;
                if (m_wait == RT) m_to = 1;
            end
        end else if (m_owner == 3) begin
            m_idle--;
            if (m_idle == 0) begin
                if (sr && cr) m_owner = (m_last == 1) ? 2 : 1;
                else if (sr) m_owner = 1;
                else if (cr) m_owner = 2;
                else begin m_owner = 0; m_ask = 0; end
                if (m_owner != 0) m_last = m_owner;
            end
        end else if ((m_owner == 1 && !sr) || (m_owner == 2 && !cr)) begin
            m_owner = 3; m_idle = TC;
        end
    endtask

    task automatic test_reset();
        ce_r = 1'b1; msh_bgr_n = 1'b1; ssh_breq_n = 1'b1; scu_breq_n = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs(), 6'b111000);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL reset_idle: got %b want %b", obs(), 6'b111000);
        end
    endtask

    task automatic test_single();
        ssh_breq_n = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b011000) begin
            errors++; $display("FAIL single_brls: got %b want %b", obs(), 6'b011000);
        end
        step();
        checks++;
        if (obs() !== 6'b011000) begin
            errors++; $display("FAIL single_wait: got %b want %b", obs(), 6'b011000);
        end
        msh_bgr_n = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b011110) begin
            errors++; $display("FAIL single_turn: got %b want %b", obs(), 6'b011110);
        end
        step();
        checks++;
        if (obs() !== 6'b001010) begin
            errors++; $display("FAIL single_grant: got %b want %b", obs(), 6'b001010);
        end
        msh_bgr_n = 1'b1;  // protocol error while granted: must be ignored
        step();
        checks++;
        if (obs() !== 6'b001010) begin
            errors++; $display("FAIL single_hold: got %b want %b", obs(), 6'b001010);
        end
        msh_bgr_n = 1'b0;
        ssh_breq_n = 1'b1;
        step();
        checks++;
        if (obs() !== 6'b011110) begin
            errors++; $display("FAIL single_drop: got %b want %b", obs(), 6'b011110);
        end
        step();
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL single_return: got %b want %b", obs(), 6'b111000);
        end
        msh_bgr_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ssh_breq_n = 1'b0; scu_breq_n = 1'b0;
        step();
        msh_bgr_n = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 6'b010100) begin
            errors++; $display("FAIL b2b_scu_first: got %b want %b", obs(), 6'b010100);
        end
        scu_breq_n = 1'b1;
        step();
        checks++;
        if (obs() !== 6'b011110) begin
            errors++; $display("FAIL b2b_turn: got %b want %b", obs(), 6'b011110);
        end
        step();
        checks++;
        if (obs() !== 6'b001010) begin
            errors++; $display("FAIL b2b_ssh_next: got %b want %b", obs(), 6'b001010);
        end
        scu_breq_n = 1'b0;  // must not pre-empt SSH
        step();
        checks++;
        if (obs() !== 6'b001010) begin
            errors++; $display("FAIL b2b_no_preempt: got %b want %b", obs(), 6'b001010);
        end
        ssh_breq_n = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== 6'b010100) begin
            errors++; $display("FAIL b2b_scu_again: got %b want %b", obs(), 6'b010100);
        end
        scu_breq_n = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL b2b_return: got %b want %b", obs(), 6'b111000);
        end
        msh_bgr_n = 1'b1;
        step();
    endtask

    task automatic test_withdraw();
        bit granted = 0;
        ssh_breq_n = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b011000) begin
            errors++; $display("FAIL withdraw_brls: got %b want %b", obs(), 6'b011000);
        end
        ssh_breq_n = 1'b1;
        step();
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL withdraw_return: got %b want %b", obs(), 6'b111000);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (!ssh_back_n || !scu_back_n) granted = 1;
        end
        checks++;
        if (granted !== 1'b0) begin
            errors++; $display("FAIL withdraw_no_grant: got %b want %b", granted, 1'b0);
        end
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        ssh_breq_n = 1'b0;
        step();
        for (int i = 1; i <= 300; i++) begin
            step();
            exp = {5'b01100, (i >= 255) ? 1'b1 : 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL timeout_cycle_%0d: got %b want %b", i, obs(), exp);
            end
        end
        msh_bgr_n = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 6'b001011) begin
            errors++; $display("FAIL timeout_grant: got %b want %b", obs(), 6'b001011);
        end
        ssh_breq_n = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== 6'b111001) begin
            errors++; $display("FAIL timeout_sticky: got %b want %b", obs(), 6'b111001);
        end
        msh_bgr_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        scu_breq_n = 1'b0;
        step();
        msh_bgr_n = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 6'b010100) begin
            errors++; $display("FAIL rstmid_tenure: got %b want %b", obs(), 6'b010100);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 6'b111000) begin
            errors++; $display("FAIL rstmid_async: got %b want %b", obs(), 6'b111000);
        end
        msh_bgr_n = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (obs() !== 6'b011000) begin
            errors++; $display("FAIL rstmid_rereq: got %b want %b", obs(), 6'b011000);
        end
        msh_bgr_n = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 6'b010100) begin
            errors++; $display("FAIL rstmid_regrant: got %b want %b", obs(), 6'b010100);
        end
        scu_breq_n = 1'b1;
        step();
        step();
        msh_bgr_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [5:0] exp;
        bit bad;
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            ce_r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ssh_breq_n = ~ssh_breq_n;
            if ($urandom_range(0, 7) == 0) scu_breq_n = ~scu_breq_n;
            if (msh_brls_n) msh_bgr_n = ($urandom_range(0, 15) != 0);
            else            msh_bgr_n = ($urandom_range(0, 2) == 0);
            if (ce_r) model_step();
            step();
            exp = {~m_ask, (m_owner != 1), (m_owner != 2), 2'(m_owner), m_to};
            checks++;
            if (obs() !== exp) begin
                errors++; $display("FAIL random_model_%0d: got %b want %b", i, obs(), exp);
            end
            bad = (!ssh_back_n && !scu_back_n)
               || ((!ssh_back_n || !scu_back_n) && (msh_brls_n || owner == 2'd0))
               || ((owner == 2'd1) != !ssh_back_n) || ((owner == 2'd2) != !scu_back_n);
            checks++;
            if (bad) begin
                errors++; $display("FAIL random_invariant_%0d: got %b want no violation", i, obs());
            end
        end
        ce_r = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
